// File: rtl/xy_step_generator.sv
// xy_step_generator
//   Two-axis step/direction pulse generator with signed 32-bit position
//   tracking. Each axis runs an identical IDLE/SETUP/HIGH/LOW machine.
//
//   Parameters
//     PERIOD_SCALE : clock cycles per speed unit, period P = (256 - spd) * PERIOD_SCALE
//     PULSE_WIDTH  : cycles step is held high (1 <= PULSE_WIDTH < PERIOD_SCALE)
//     DIR_SETUP    : cycles dir is stable before the first step after start/reversal (>= 1)
//
//   Ports
//     clock, ctrl_reset          : clock and synchronous active-high reset
//     xSpeed/ySpeed [31:0]       : bits [7:0] = spd, 0 stops the axis
//     xDirection/yDirection [31:0]: bit 0 = direction, 1 counts up
//     zero_position              : clears both positions on the next edge
//     x_step/y_step, x_dir/y_dir : driver outputs
//     x_moving/y_moving          : axis machine not idle
//     currentX/currentY [31:0]   : two's complement step positions
//
//   Handshake: none. Speed/direction words are levels sampled only at period
//   boundaries (IDLE, or the last LOW cycle), never mid-period.

module xy_step_axis #(
  parameter int PERIOD_SCALE = 1000,
  parameter int PULSE_WIDTH  = 100,
  parameter int DIR_SETUP    = 50
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [7:0]  i_spd,
  input  logic        i_dir,
  input  logic        i_zero,
  output logic        o_step,
  output logic        o_dir,
  output logic [1:0]  o_state,
  output logic [31:0] o_pos
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
  localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);
  localparam logic [31:0] HIGH_LOAD  = 32'(PULSE_WIDTH - 1);
  localparam logic [31:0] PW_PLUS1   = 32'(PULSE_WIDTH + 1);

  state_t      r_state, w_next_state;
  logic [31:0] r_cnt, w_next_cnt;
  logic [31:0] r_period, w_next_period;
  logic [31:0] w_new_period;
  logic [31:0] r_pos;
  logic        r_dir, w_next_dir;
  logic        w_step_rise;

  assign w_new_period = (32'd256 - {24'd0, i_spd}) * 32'(PERIOD_SCALE);

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_period = r_period;
    w_next_dir    = r_dir;
    w_step_rise   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_spd != 8'd0) begin
          w_next_period = w_new_period;
          w_next_dir    = i_dir;
          w_next_cnt    = SETUP_LOAD;
          w_next_state  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == 32'd0) begin
          w_next_cnt   = HIGH_LOAD;
          w_next_state = S_HIGH;
          w_step_rise  = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 32'd1;
        end
      end
      S_HIGH: begin
        if (r_cnt == 32'd0) begin
          // LOW fills the remainder of the period: P - PULSE_WIDTH cycles.
          w_next_cnt   = r_period - PW_PLUS1;
          w_next_state = S_LOW;
        end else begin
          w_next_cnt = r_cnt - 32'd1;
        end
      end
      S_LOW: begin
        if (r_cnt == 32'd0) begin
          // Period boundary: the only point where speed/direction are resampled.
          if (i_spd == 8'd0) begin
            w_next_state = S_IDLE;
          end else if (i_dir != r_dir) begin
            w_next_dir    = i_dir;
            w_next_period = w_new_period;
            w_next_cnt    = SETUP_LOAD;
            w_next_state  = S_SETUP;
          end else begin
            w_next_period = w_new_period;
            w_next_cnt    = HIGH_LOAD;
            w_next_state  = S_HIGH;
            w_step_rise   = 1'b1;
          end
        end else begin
          w_next_cnt = r_cnt - 32'd1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 32'd0;
      r_period <= 32'd0;
      r_dir    <= 1'b0;
      r_pos    <= 32'd0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_next_cnt;
      r_period <= w_next_period;
      r_dir    <= w_next_dir;
      // Zeroing wins over a step landing on the same edge. The direction of a
      // rising step is always the already-latched one.
      if (i_zero) begin
        r_pos <= 32'd0;
      end else if (w_step_rise) begin
        r_pos <= r_dir ? (r_pos + 32'd1) : (r_pos - 32'd1);
      end
    end
  end

  assign o_step  = (r_state == S_HIGH);
  assign o_dir   = r_dir;
  assign o_state = r_state;
  assign o_pos   = r_pos;

endmodule

module xy_step_generator #(
  parameter int PERIOD_SCALE = 1000,
  parameter int PULSE_WIDTH  = 100,
  parameter int DIR_SETUP    = 50
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] xSpeed,
  input  logic [31:0] xDirection,
  input  logic [31:0] ySpeed,
  input  logic [31:0] yDirection,
  input  logic        zero_position,
  output logic        x_step,
  output logic        x_dir,
  output logic        y_step,
  output logic        y_dir,
  output logic        x_moving,
  output logic        y_moving,
  output logic [31:0] currentX,
  output logic [31:0] currentY
);

  logic [1:0] w_x_state;
  logic [1:0] w_y_state;

  // Only spd bits [7:0] and direction bit 0 carry meaning.
  logic w_unused;
  assign w_unused = &{1'b0, xSpeed[31:8], xDirection[31:1], ySpeed[31:8], yDirection[31:1]};

  xy_step_axis #(
    .PERIOD_SCALE(PERIOD_SCALE), .PULSE_WIDTH(PULSE_WIDTH), .DIR_SETUP(DIR_SETUP)
  ) u_x_axis (
    .clock(clock), .ctrl_reset(ctrl_reset), .i_spd(xSpeed[7:0]), .i_dir(xDirection[0]),
    .i_zero(zero_position), .o_step(x_step), .o_dir(x_dir), .o_state(w_x_state), .o_pos(currentX)
  );

  xy_step_axis #(
    .PERIOD_SCALE(PERIOD_SCALE), .PULSE_WIDTH(PULSE_WIDTH), .DIR_SETUP(DIR_SETUP)
  ) u_y_axis (
    .clock(clock), .ctrl_reset(ctrl_reset), .i_spd(ySpeed[7:0]), .i_dir(yDirection[0]),
    .i_zero(zero_position), .o_step(y_step), .o_dir(y_dir), .o_state(w_y_state), .o_pos(currentY)
  );

  // State code 0 is IDLE in the axis machine.
  assign x_moving = (w_x_state != 2'd0);
  assign y_moving = (w_y_state != 2'd0);

endmodule
